// File: rtl/reg_dest_pipe_if.sv
// reg_dest_pipe_if: ID-stage tags in, stage tags and hazard controls out
interface reg_dest_pipe_if #(parameter int NB_REG = 5, parameter int NB_CNT = 16);
  logic              enable;
  logic              flush;
  logic [NB_REG-1:0] id_rs;
  logic [NB_REG-1:0] id_rt;
  logic [NB_REG-1:0] id_rd;
  logic              id_wr_en;
  logic              id_mem_rd;
  logic              id_uses_rt;
  logic [NB_REG-1:0] id_ex_rs;
  logic [NB_REG-1:0] id_ex_rt;
  logic [NB_REG-1:0] ex_mem_rd;
  logic              ex_mem_wr_en;
  logic [NB_REG-1:0] mem_wb_rd;
  logic              mem_wb_wr_en;
  logic              stall;
  logic              pc_wr_en;
  logic              if_id_wr_en;
  logic [NB_CNT-1:0] stall_count;
  modport master (
    output enable, flush, id_rs, id_rt, id_rd, id_wr_en, id_mem_rd, id_uses_rt,
    input  id_ex_rs, id_ex_rt, ex_mem_rd, ex_mem_wr_en, mem_wb_rd, mem_wb_wr_en,
           stall, pc_wr_en, if_id_wr_en, stall_count
  );
  modport slave (
    input  enable, flush, id_rs, id_rt, id_rd, id_wr_en, id_mem_rd, id_uses_rt,
    output id_ex_rs, id_ex_rt, ex_mem_rd, ex_mem_wr_en, mem_wb_rd, mem_wb_wr_en,
           stall, pc_wr_en, if_id_wr_en, stall_count
  );
endinterface

// File: rtl/reg_dest_pipe.sv
// reg_dest_pipe: carries register tags through ID/EX, EX/MEM, MEM/WB and
// inserts a one-cycle bubble on load-use hazards
module reg_dest_pipe #(
    parameter int NB_REG = 5,
    parameter int NB_CNT = 16
) (
    input logic i_clock,
    input logic i_reset,
    reg_dest_pipe_if.slave bus
);
    logic [NB_REG-1:0] ie_rs, ie_rt, ie_rd, em_rd, mw_rd;
    logic              ie_wr_en, ie_mem_rd, em_wr_en, mw_wr_en;
    logic [NB_CNT-1:0] cnt;
    logic              hz;

    // a load to $0 never stalls since its value is never consumed
    assign hz = ie_mem_rd && (ie_rd != '0) &&
                (ie_rd == bus.id_rs || (bus.id_uses_rt && ie_rd == bus.id_rt));
    assign bus.stall        = hz && !bus.flush;
    assign bus.pc_wr_en     = bus.enable && !bus.stall;
    assign bus.if_id_wr_en  = bus.enable && !bus.stall;
    assign bus.id_ex_rs     = ie_rs;
    assign bus.id_ex_rt     = ie_rt;
    assign bus.ex_mem_rd    = em_rd;
    assign bus.ex_mem_wr_en = em_wr_en;
    assign bus.mem_wb_rd    = mw_rd;
    assign bus.mem_wb_wr_en = mw_wr_en;
    assign bus.stall_count  = cnt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            {ie_rs, ie_rt, ie_rd, ie_wr_en, ie_mem_rd} <= '0;
            {em_rd, em_wr_en, mw_rd, mw_wr_en}         <= '0;
            cnt                                        <= '0;
        end else if (bus.enable) begin
            em_rd    <= ie_rd;
            em_wr_en <= ie_wr_en;
            mw_rd    <= em_rd;
            mw_wr_en <= em_wr_en;
            if (bus.flush || bus.stall)
                {ie_rs, ie_rt, ie_rd, ie_wr_en, ie_mem_rd} <= '0;
            else
                {ie_rs, ie_rt, ie_rd, ie_wr_en, ie_mem_rd} <=
                    {bus.id_rs, bus.id_rt, bus.id_rd, bus.id_wr_en, bus.id_mem_rd};
            if (bus.stall && !(&cnt))
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_dest_pipe.sv
// tb_reg_dest_pipe: vector table plus stage scoreboard, with reset and
// counter-saturation sequences
module tb_reg_dest_pipe;
    localparam int NB_REG = 5;
    localparam int NB_CNT = 4;
    localparam logic [NB_CNT-1:0] CMAX = '1;

    typedef struct {
        logic [NB_REG-1:0] rs, rt, rd;
        logic wr, mrd, ut, fl, en, st;
    } vec_t;
    typedef struct {
        logic [NB_REG-1:0] rs, rt, rd;
        logic wr;
    } stage_t;

    logic clk = 0;
    logic rst_n = 0;
    int passed = 0, total = 0;
    stage_t sb[$];
    logic [NB_CNT-1:0] cnt_exp;
    vec_t tbl[22];

    reg_dest_pipe_if #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) bus ();
    reg_dest_pipe #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
        .i_clock(clk), .i_reset(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int rs, int rt, int rd, bit wr, bit mrd, bit ut,
                                bit fl, bit en, bit st);
        vec_t v;
        v.rs = NB_REG'(rs); v.rt = NB_REG'(rt); v.rd = NB_REG'(rd);
        v.wr = wr; v.mrd = mrd; v.ut = ut; v.fl = fl; v.en = en; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        stage_t z;
        z = '{rs: '0, rt: '0, rd: '0, wr: 1'b0};
        sb.delete();
        repeat (3) sb.push_back(z);
        cnt_exp = '0;
    endtask

    task automatic chk_stages();
        chk("id_ex_rs", int'(bus.id_ex_rs), int'(sb[2].rs));
        chk("id_ex_rt", int'(bus.id_ex_rt), int'(sb[2].rt));
        chk("ex_mem_rd", int'(bus.ex_mem_rd), int'(sb[1].rd));
        chk("ex_mem_wr_en", int'(bus.ex_mem_wr_en), int'(sb[1].wr));
        chk("mem_wb_rd", int'(bus.mem_wb_rd), int'(sb[0].rd));
        chk("mem_wb_wr_en", int'(bus.mem_wb_wr_en), int'(sb[0].wr));
        chk("stall_count", int'(bus.stall_count), int'(cnt_exp));
    endtask

    task automatic drive(input vec_t v);
        bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_rd = v.rd;
        bus.id_wr_en = v.wr; bus.id_mem_rd = v.mrd; bus.id_uses_rt = v.ut;
        bus.flush = v.fl; bus.enable = v.en;
    endtask

    // called just after a rising edge; returns just after the next one
    task automatic step(input vec_t v);
        stage_t s;
        drive(v);
        #1;
        chk("stall", int'(bus.stall), int'(v.st));
        chk("pc_wr_en", int'(bus.pc_wr_en), int'(v.en && !v.st));
        chk("if_id_wr_en", int'(bus.if_id_wr_en), int'(v.en && !v.st));
        @(posedge clk);
        #1;
        if (v.en) begin
            s = (v.fl || v.st) ? '{rs: '0, rt: '0, rd: '0, wr: 1'b0}
                               : '{rs: v.rs, rt: v.rt, rd: v.rd, wr: v.wr};
            sb.push_back(s);
            void'(sb.pop_front());
            if (v.st && cnt_exp != CMAX) cnt_exp++;
        end
        chk_stages();
    endtask

    initial begin
        //            rs rt rd wr mrd ut fl en st
        tbl[0]  = mk(1, 2, 5, 1, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(3, 0, 8, 1, 1, 0, 0, 1, 0);
        tbl[5]  = mk(8, 4, 9, 1, 0, 0, 0, 1, 1);
        tbl[6]  = mk(8, 4, 9, 1, 0, 0, 0, 1, 0);
        tbl[7]  = mk(1, 0, 8, 1, 1, 0, 0, 1, 0);
        tbl[8]  = mk(2, 8, 10, 1, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 0, 8, 1, 1, 0, 0, 1, 0);
        tbl[10] = mk(2, 8, 10, 1, 0, 1, 0, 1, 1);
        tbl[11] = mk(2, 8, 10, 1, 0, 1, 0, 1, 0);
        tbl[12] = mk(1, 0, 0, 1, 1, 0, 0, 1, 0);
        tbl[13] = mk(0, 0, 3, 1, 0, 0, 0, 1, 0);
        tbl[14] = mk(1, 0, 8, 1, 1, 0, 0, 1, 0);
        tbl[15] = mk(8, 0, 4, 1, 0, 0, 1, 1, 0);
        tbl[16] = mk(0, 0, 7, 1, 1, 0, 0, 1, 0);
        tbl[17] = mk(7, 0, 6, 1, 0, 0, 0, 0, 1);
        tbl[18] = mk(7, 0, 6, 1, 0, 0, 0, 0, 1);
        tbl[19] = mk(7, 0, 6, 1, 0, 0, 0, 0, 1);
        tbl[20] = mk(7, 0, 6, 1, 0, 0, 0, 1, 1);
        tbl[21] = mk(7, 0, 6, 1, 0, 0, 0, 1, 0);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_stages();
        chk("reset_stall", int'(bus.stall), 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i]);

        // asynchronous reset while a load-use stall is pending
        step(mk(1, 0, 8, 1, 1, 0, 0, 1, 0));
        drive(mk(8, 0, 9, 1, 0, 0, 0, 1, 0));
        #1;
        chk("pre_reset_stall", int'(bus.stall), 1);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk_stages();
        chk("async_reset_stall", int'(bus.stall), 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // push the counter past its all-ones value
        for (int k = 0; k < 20; k++) begin
            step(mk(1, 0, 8, 1, 1, 0, 0, 1, 0));
            step(mk(8, 0, 9, 1, 0, 0, 0, 1, 1));
            step(mk(8, 0, 9, 1, 0, 0, 0, 1, 0));
        end
        chk("count_saturated", int'(bus.stall_count), int'(CMAX));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
